// File: rtl/regfile_sb.sv
// Parametrised integer register file with load-use scoreboard, write bypass,
// registered debug read port and a sequential scrub engine that zeroes the file.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_pending,
  output logic            rs2_pending,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  output logic            wr_ready,
  input  logic            sb_set_en,
  input  logic [AW-1:0]   sb_set_addr,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            clr_req,
  output logic            busy
);

  localparam int NREG = 1 << AW;

  typedef enum logic {IDLE, SCRUB} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   counter_q;
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend_q;

  logic wr_acc, sb_set_ok, scrub_start;
  logic rs1_byp, rs2_byp;

  assign wr_acc      = wr_en && !busy && (wr_addr != '0);
  assign sb_set_ok   = sb_set_en && !busy && (sb_set_addr != '0);
  assign scrub_start = (state_q == IDLE) && clr_req;
  assign wr_ready    = !busy;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: a scrub runs from register 1 up to NREG-1 and then stops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req) state_d = SCRUB;
      SCRUB:   if (counter_q == AW'(NREG - 1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = 1'b0;
    if (state_q == SCRUB) busy = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every process sees
  // pre-edge values; blocking here would make results depend on process order.
  always_ff @(posedge clk) begin
    if (rst)                   counter_q <= '0;
    else if (scrub_start)      counter_q <= AW'(1);
    else if (state_q == SCRUB) counter_q <= (counter_q == AW'(NREG - 1)) ? '0 : counter_q + AW'(1);
  end

  // NOTE: the register array is reset explicitly because a core reset must leave
  // the file zeroed; this costs a reset net on every storage flop.
  // Entry 0 is only ever written by reset, so it stays zero and is masked on reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (busy) begin
      regs[counter_q] <= '0;
    end else if (wr_acc) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard: a same-edge set beats the writeback clear (a new producer is in flight).
  always_ff @(posedge clk) begin
    if (rst || scrub_start) begin
      pend_q <= '0;
    end else begin
      if (wr_acc)    pend_q[wr_addr]     <= 1'b0;
      if (sb_set_ok) pend_q[sb_set_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dbg_data <= '0;
    else     dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
  end

  assign rs1_byp = (BYPASS != 0) && wr_acc && (wr_addr == rs1_addr);
  assign rs2_byp = (BYPASS != 0) && wr_acc && (wr_addr == rs2_addr);

  assign rs1_data = (rs1_addr == '0) ? '0 : rs1_byp ? wr_data : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : rs2_byp ? wr_data : regs[rs2_addr];

  // A bypassed write hides the pending bit it is about to clear, unless the
  // same register is being re-marked this cycle.
  assign rs1_pending = (rs1_addr == '0) ? 1'b0 :
                       (rs1_byp && !(sb_set_ok && sb_set_addr == rs1_addr)) ? 1'b0 :
                       pend_q[rs1_addr];
  assign rs2_pending = (rs2_addr == '0) ? 1'b0 :
                       (rs2_byp && !(sb_set_ok && sb_set_addr == rs2_addr)) ? 1'b0 :
                       pend_q[rs2_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a bypassing instance and a non-bypassing
// instance driven by the same stimulus, checked against hand-computed values.
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, sb_set_addr, dbg_addr;
  logic [XLEN-1:0] wr_data;
  logic            wr_en, sb_set_en, clr_req;

  logic [XLEN-1:0] rs1_data, rs2_data, dbg_data;
  logic            rs1_pending, rs2_pending, wr_ready, busy;
  logic [XLEN-1:0] nb_rs1_data, nb_rs2_data, nb_dbg_data;
  logic            nb_rs1_pending, nb_rs2_pending, nb_wr_ready, nb_busy;

  int vectors     = 0;
  int miscompares = 0;
  int n;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(1)) u_dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .clr_req(clr_req), .busy(busy)
  );

  regfile_sb #(.XLEN(XLEN), .AW(AW), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(nb_rs1_data), .rs2_data(nb_rs2_data),
    .rs1_pending(nb_rs1_pending), .rs2_pending(nb_rs2_pending),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(nb_wr_ready),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data),
    .clr_req(clr_req), .busy(nb_busy)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0; clr_req = 1'b0;
    rs1_addr = '0; rs2_addr = '0; dbg_addr = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_busy",     32'(busy), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    check("rst_dbg",      dbg_data, 0);
    rs1_addr = 5'd5; #1;
    check("rst_x5",       rs1_data, 0);
    check("rst_x5_pend",  32'(rs1_pending), 0);

    // Write x5; bypass shows it combinationally, stored copy appears after the edge.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; #1;
    check("x5_bypass",    rs1_data, 32'hDEADBEEF);
    check("x5_nb_old",    nb_rs1_data, 0);
    tick(); wr_en = 1'b0; #1;
    check("x5_read",      rs1_data, 32'hDEADBEEF);
    check("x5_nb_read",   nb_rs1_data, 32'hDEADBEEF);

    // Writes to x0 are dropped.
    rs2_addr = '0;
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'h1234; #1;
    check("x0_same",      rs2_data, 0);
    tick(); wr_en = 1'b0; #1;
    check("x0_after",     rs2_data, 0);
    check("x0_after_nb",  nb_rs2_data, 0);

    // x7 bypass versus stored value.
    rs1_addr = 5'd7;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5; #1;
    check("x7_bypass",    rs1_data, 32'hA5A5A5A5);
    check("x7_nb_old",    nb_rs1_data, 0);
    tick(); wr_en = 1'b0; #1;
    check("x7_nb_new",    nb_rs1_data, 32'hA5A5A5A5);

    // Scoreboard on x10.
    rs1_addr = 5'd10;
    sb_set_en = 1'b1; sb_set_addr = 5'd10; #1;
    check("x10_pend_pre", 32'(rs1_pending), 0);
    tick(); sb_set_en = 1'b0; #1;
    check("x10_pend_set", 32'(rs1_pending), 1);
    check("x10_pend_nb",  32'(nb_rs1_pending), 1);
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h111; #1;
    check("x10_pend_byp", 32'(rs1_pending), 0);
    check("x10_pend_nbh", 32'(nb_rs1_pending), 1);
    tick(); wr_en = 1'b0; #1;
    check("x10_pend_clr", 32'(rs1_pending), 0);
    check("x10_data",     rs1_data, 32'h111);
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h222;
    sb_set_en = 1'b1; sb_set_addr = 5'd10;
    tick(); wr_en = 1'b0; sb_set_en = 1'b0; #1;
    check("x10_set_wins", 32'(rs1_pending), 1);
    check("x10_data2",    nb_rs1_data, 32'h222);

    // Debug port has one cycle of latency.
    write(5'd19, 32'hCAFEF00D);
    dbg_addr = 5'd19; #1;
    check("dbg_pre",      dbg_data, 0);
    tick();
    check("dbg_x19",      dbg_data, 32'hCAFEF00D);

    // Fill x1..x31 with their index, mark x3 pending, then scrub.
    for (int i = 1; i < 32; i++) write(AW'(i), XLEN'(i));
    sb_set_en = 1'b1; sb_set_addr = 5'd3;
    tick(); sb_set_en = 1'b0;
    rs1_addr = 5'd3; #1;
    check("fill_pend3",   32'(rs1_pending), 1);
    clr_req = 1'b1;
    tick(); clr_req = 1'b0; #1;
    check("scr_busy",     32'(busy), 1);
    check("scr_wr_ready", 32'(wr_ready), 0);
    check("scr_pend3",    32'(rs1_pending), 0);
    // Write and scoreboard set attempted in the first scrub cycle must be ignored.
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hFFFF;
    sb_set_en = 1'b1; sb_set_addr = 5'd12;
    rs1_addr = 5'd1; rs2_addr = 5'd31;
    tick(); wr_en = 1'b0; sb_set_en = 1'b0; #1;
    check("scr_x1_zero",  rs1_data, 0);
    check("scr_x31_kept", rs2_data, 31);
    rs1_addr = 5'd20; #1;
    check("scr_x20_kept", rs1_data, 20);
    n = 1;
    while (busy && n < 100) begin
      n++;
      tick();
    end
    check("scr_cycles",   n, 31);
    check("scr_done",     32'(busy), 0);
    check("scr_ready",    32'(wr_ready), 1);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = AW'(i);
      tick();
      check($sformatf("scr_dbg%0d", i), dbg_data, 0);
    end
    rs1_addr = 5'd10; rs2_addr = 5'd12; #1;
    check("scr_pend10",   32'(rs1_pending), 0);
    check("scr_pend12",   32'(rs2_pending), 0);
    write(5'd6, 32'h66);
    rs1_addr = 5'd6; #1;
    check("post_scr_wr",  rs1_data, 32'h66);

    // Reset in the middle of a scrub aborts it and zeroes everything.
    write(5'd3, 32'h77);
    write(5'd20, 32'h20);
    clr_req = 1'b1;
    tick(); clr_req = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("mid_busy",     32'(busy), 1);
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    check("abort_busy",   32'(busy), 0);
    rs1_addr = 5'd20; rs2_addr = 5'd6; #1;
    check("abort_x20",    rs1_data, 0);
    check("abort_x6",     rs2_data, 0);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55; #1;
    check("abort_ready",  32'(wr_ready), 1);
    tick(); wr_en = 1'b0;
    rs1_addr = 5'd3; #1;
    check("abort_x3",     nb_rs1_data, 32'h55);
    check("abort_x3_byp", rs1_data, 32'h55);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised integer register file with scoreboard and scrub sequencer, the successor to the fixed 32×32 two-read/one-write register file in the RV32I core. Adds configurable width and depth, write-to-read bypass, per-register pending (scoreboard) bits for load-use hazard detection, a registered debug read port with selectable address, and a sequential scrub engine that zeroes the file without a core reset. Sits between the decode stage (reads, scoreboard set) and writeback (write, scoreboard clear).

## Interface
- XLEN, 32, data width in bits
- AW, 5, address width; NREG = 2^AW registers, index 0 hardwired to zero
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- rs1_addr, rs2_addr  in  AW  read port addresses
- rs1_data, rs2_data  out  XLEN  combinational read data
- rs1_pending, rs2_pending  out  1  scoreboard bit of addressed register (combinational)
- wr_en  in  1  write request
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- wr_ready  out  1  write accepted this cycle (low while scrubbing)
- sb_set_en  in  1  mark sb_set_addr pending (issue of long-latency producer)
- sb_set_addr  in  AW  register to mark
- dbg_addr  in  AW  debug read address
- dbg_data  out  XLEN  registered debug read data
- clr_req  in  1  start scrub (single-cycle pulse sufficient)
- busy  out  1  scrub in progress

## Operation
- Storage: NREG-1 registers of XLEN bits plus scoreboard vector of NREG bits; entry 0 reads 0 and is never pending.
- Write: accepted when wr_en && wr_ready && wr_addr != 0; updates register and clears its pending bit at the edge. Writes to 0 are dropped silently.
- Read: rsN_data = 0 if rsN_addr == 0; else if BYPASS && accepted write to same address this cycle, wr_data; else stored value. rsN_pending likewise returns 0 when the same-cycle accepted write clears it (BYPASS=1 only) unless sb_set to same address in same cycle.
- Scoreboard set: sb_set_en with sb_set_addr != 0 sets the bit. Simultaneous set and accepted write to same address: set wins (new producer in flight), register still takes wr_data. sb_set_en ignored while busy.
- Debug: dbg_data <= value of register dbg_addr (0 for addr 0) at each edge; no bypass.
- Scrub FSM, states IDLE, SCRUB:
  - IDLE: clr_req -> SCRUB, counter <= 1, all pending bits cleared on that edge.
  - SCRUB: register[counter] <= 0 each cycle, counter increments; when counter == NREG-1 is written -> IDLE.
  - clr_req in SCRUB ignored. busy = (state == SCRUB). wr_ready = !busy.
- Reads during SCRUB allowed; return current (partially scrubbed) contents.

## Timing
- Reset (rst high at edge): all registers 0, all pending bits 0, state IDLE, counter 0, dbg_data 0; busy 0, wr_ready 1 in the cycle after. Reset mid-scrub aborts to IDLE with file fully zeroed.
- Read latency 0 (combinational); write visible to non-bypassed read the cycle after acceptance.
- dbg_data latency 1 cycle.
- Scrub duration NREG-1 cycles (31 for AW=5): clr_req sampled at edge E, busy high from E through the edge writing register NREG-1, low on the following cycle; first write accepted next cycle.
- Pending bit set at edge E is visible on rsN_pending after E.

## Test plan
- Reset then write 0xDEADBEEF to x5, read rs1=5 next cycle -> 0xDEADBEEF; write 0x1234 to x0, read rs2=0 -> 0.
- BYPASS=1: write x7=0xA5A5A5A5 while rs1_addr=7 same cycle -> rs1_data=0xA5A5A5A5 combinationally; BYPASS=0 -> old value until next cycle.
- sb_set x10, next cycle rs1_pending(10)=1; write x10 -> pending 0 after edge; simultaneous sb_set and write x10 -> pending 1, x10 holds written data.
- Fill x1..x31 with index values, pulse clr_req -> busy 31 cycles, wr_en during scrub gives wr_ready=0 and no update; afterwards all dbg_data reads 0, all pending 0.
- Assert rst at scrub cycle 10 -> busy 0 next cycle, all registers 0, write x3=0x55 then accepted.
- dbg_addr=19 after writing x19=0xCAFEF00D -> dbg_data=0xCAFEF00D one cycle after address applied.
